// File: rtl/ysyx_25040111_csru.sv
// CSR/trap sequencing unit: drives the CSR file port over several cycles per instruction.
// Optional feature macro: CSRU_EBREAK_EN (op 5 traps as EBREAK instead of illegal).
module ysyx_25040111_csru #(
  parameter logic [3:0] CAUSE_ECALL   = 4'd11,
  parameter logic [3:0] CAUSE_ILLEGAL = 4'd2,
  parameter logic [3:0] CAUSE_EBREAK  = 4'd3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [2:0]  in_op,
  input  logic [11:0] in_csr_addr,
  input  logic [31:0] in_rs1_data,
  input  logic        in_rs1_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_rd_wen,
  output logic [31:0] out_rd_data,
  output logic [31:0] out_npc,
  output logic        out_redirect,
  output logic        csr_ren,
  output logic        csr_wen,
  output logic        csr_err,
  output logic [11:0] csr_raddr,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic [3:0]  csr_errtp,
  input  logic [31:0] csr_rdata
);

  localparam logic [2:0] OP_CSRRW  = 3'd0;
  localparam logic [2:0] OP_CSRRS  = 3'd1;
  localparam logic [2:0] OP_CSRRC  = 3'd2;
  localparam logic [2:0] OP_ECALL  = 3'd3;
  localparam logic [2:0] OP_MRET   = 3'd4;
  localparam logic [2:0] OP_EBREAK = 3'd5;

  localparam logic [11:0] ADDR_MTVEC = 12'h305;
  localparam logic [11:0] ADDR_MEPC  = 12'h341;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RDEPC,
    S_TRAP_EPC,
    S_TRAP_CAUSE,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [2:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] rs1_q;
  logic        rs1z_q;
  logic [31:0] pc_q;
  logic [3:0]  cause_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_data_q;
  logic        rd_wen_q;
  logic [31:0] npc_q;
  logic        redirect_q;

  logic        accept;
  state_t      acc_state;
  logic [3:0]  acc_cause;
  logic [31:0] new_val;
  logic        write_needed;
  logic        illegal_wr;

  assign accept = in_valid & in_ready;

  // Entry decode: where a freshly accepted op goes and which cause a trap would carry.
  always_comb begin
    acc_state = S_TRAP_EPC;
    acc_cause = CAUSE_ILLEGAL;
    case (in_op)
      OP_CSRRW, OP_CSRRS, OP_CSRRC: acc_state = S_READ;
      OP_MRET:                      acc_state = S_RDEPC;
      OP_ECALL:                     acc_cause = CAUSE_ECALL;
`ifdef CSRU_EBREAK_EN
      OP_EBREAK:                    acc_cause = CAUSE_EBREAK;
`else
      OP_EBREAK:                    acc_cause = CAUSE_ILLEGAL;
`endif
      default:                      acc_cause = CAUSE_ILLEGAL;
    endcase
  end

  always_comb begin
    new_val = csr_rdata;
    case (op_q)
      OP_CSRRW: new_val = rs1_q;
      OP_CSRRS: new_val = csr_rdata | rs1_q;
      OP_CSRRC: new_val = csr_rdata & ~rs1_q;
      default:  new_val = csr_rdata;
    endcase
  end

  assign write_needed = (op_q == OP_CSRRW) | ~rs1z_q;
  assign illegal_wr   = write_needed & (addr_q[11:10] == 2'b11);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    csr_ren   = 1'b0;
    csr_wen   = 1'b0;
    csr_err   = 1'b0;
    csr_raddr = '0;
    csr_waddr = '0;
    csr_wdata = '0;
    csr_errtp = '0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nxt = acc_state;
      end
      S_READ: begin
        csr_ren   = 1'b1;
        csr_raddr = addr_q;
        if (illegal_wr)        state_nxt = S_TRAP_EPC;
        else if (write_needed) state_nxt = S_WRITE;
        else                   state_nxt = S_RESP;
      end
      S_WRITE: begin
        csr_wen   = 1'b1;
        csr_waddr = addr_q;
        csr_wdata = wdata_q;
        state_nxt = S_RESP;
      end
      S_RDEPC: begin
        csr_ren   = 1'b1;
        csr_raddr = ADDR_MEPC;
        state_nxt = S_RESP;
      end
      S_TRAP_EPC: begin
        csr_wen   = 1'b1;
        csr_waddr = ADDR_MEPC;
        csr_wdata = pc_q;
        state_nxt = S_TRAP_CAUSE;
      end
      S_TRAP_CAUSE: begin
        csr_err   = 1'b1;
        csr_errtp = cause_q;
        csr_ren   = 1'b1;
        csr_raddr = ADDR_MTVEC;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      addr_q     <= '0;
      rs1_q      <= '0;
      rs1z_q     <= 1'b0;
      pc_q       <= '0;
      cause_q    <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_wen_q   <= 1'b0;
      npc_q      <= '0;
      redirect_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q       <= in_op;
            addr_q     <= in_csr_addr;
            rs1_q      <= in_rs1_data;
            rs1z_q     <= in_rs1_zero;
            pc_q       <= in_pc;
            cause_q    <= acc_cause;
            rd_data_q  <= '0;
            rd_wen_q   <= 1'b0;
            npc_q      <= in_pc + 32'd4;
            redirect_q <= 1'b0;
          end
        end
        S_READ: begin
          // New value is staged so the write lands a cycle after the read.
          rd_data_q <= csr_rdata;
          wdata_q   <= new_val;
          if (illegal_wr) cause_q  <= CAUSE_ILLEGAL;
          else            rd_wen_q <= 1'b1;
        end
        S_RDEPC: begin
          npc_q      <= csr_rdata;
          redirect_q <= 1'b1;
        end
        S_TRAP_CAUSE: begin
          npc_q      <= {csr_rdata[31:2], 2'b00};
          redirect_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_rd_wen   = rd_wen_q;
  assign out_rd_data  = rd_data_q;
  assign out_npc      = npc_q;
  assign out_redirect = redirect_q;

endmodule

// File: tb/tb_ysyx_25040111_csru.sv
// Directed bench for ysyx_25040111_csru with a small behavioural CSR file attached.
module tb_ysyx_25040111_csru;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [2:0]  in_op = '0;
  logic [11:0] in_csr_addr = '0;
  logic [31:0] in_rs1_data = '0;
  logic        in_rs1_zero = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_rd_wen;
  logic [31:0] out_rd_data;
  logic [31:0] out_npc;
  logic        out_redirect;
  logic        csr_ren, csr_wen, csr_err;
  logic [11:0] csr_raddr, csr_waddr;
  logic [31:0] csr_wdata;
  logic [3:0]  csr_errtp;
  logic [31:0] csr_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ysyx_25040111_csru dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_op(in_op),
    .in_csr_addr(in_csr_addr), .in_rs1_data(in_rs1_data), .in_rs1_zero(in_rs1_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_wen(out_rd_wen),
    .out_rd_data(out_rd_data), .out_npc(out_npc), .out_redirect(out_redirect),
    .csr_ren(csr_ren), .csr_wen(csr_wen), .csr_err(csr_err),
    .csr_raddr(csr_raddr), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_errtp(csr_errtp), .csr_rdata(csr_rdata)
  );

  // Behavioural CSR file
  localparam logic [31:0] MARCHID = 32'd25040111;
  logic [31:0] m_mstatus = 32'h0000_1800;
  logic [31:0] m_mtvec   = '0;
  logic [31:0] m_mepc    = '0;
  logic [31:0] m_mcause  = '0;
  int wen_cnt = 0;
  int err_cnt = 0;

  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      12'h300: csr_rdata = m_mstatus;
      12'h305: csr_rdata = m_mtvec;
      12'h341: csr_rdata = m_mepc;
      12'h342: csr_rdata = m_mcause;
      12'hF12: csr_rdata = MARCHID;
      default: csr_rdata = '0;
    endcase
  end

  always @(posedge clock) begin
    if (csr_wen) begin
      case (csr_waddr)
        12'h300: m_mstatus <= csr_wdata;
        12'h305: m_mtvec   <= csr_wdata;
        12'h341: m_mepc    <= csr_wdata;
        12'h342: m_mcause  <= csr_wdata;
        default: ;
      endcase
      wen_cnt <= wen_cnt + 1;
    end
    if (csr_err) begin
      m_mcause <= {28'b0, csr_errtp};
      err_cnt  <= err_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, then count edges (accept edge included) until out_valid.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [11:0] addr,
                        input logic [31:0] rs1, input logic rz, input logic [31:0] pc,
                        input int exp_edges);
    int edges;
    @(negedge clock);
    check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_csr_addr = addr;
    in_rs1_data = rs1; in_rs1_zero = rz; in_pc = pc;
    @(posedge clock);
    #1 in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 20) begin
      @(posedge clock);
      #1 edges++;
    end
    check({tag, "_lat"}, edges, exp_edges);
  endtask

  task automatic take_resp;
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
  endtask

  logic [31:0] exp_eb;
  int w0, e0;

  initial begin
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_csr_ctl", {29'b0, csr_ren, csr_wen, csr_err}, 32'd0);
    check("rst_npc", out_npc, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // CSRRW mtvec
    run_op("rw_mtvec", 3'd0, 12'h305, 32'h8000_0100, 1'b0, 32'h8000_0000, 3);
    check("rw_mtvec_rdwen", {31'b0, out_rd_wen}, 32'd1);
    check("rw_mtvec_rd", out_rd_data, 32'h0);
    check("rw_mtvec_npc", out_npc, 32'h8000_0004);
    check("rw_mtvec_redir", {31'b0, out_redirect}, 32'd0);
    check("rw_mtvec_val", m_mtvec, 32'h8000_0100);
    take_resp();

    // ECALL then MRET
    run_op("ecall", 3'd3, 12'h000, 32'h0, 1'b1, 32'h8000_0010, 3);
    check("ecall_mepc", m_mepc, 32'h8000_0010);
    check("ecall_mcause", m_mcause, 32'd11);
    check("ecall_npc", out_npc, 32'h8000_0100);
    check("ecall_redir", {31'b0, out_redirect}, 32'd1);
    check("ecall_rdwen", {31'b0, out_rd_wen}, 32'd0);
    take_resp();
    run_op("mret", 3'd4, 12'h000, 32'h0, 1'b1, 32'h8000_0100, 2);
    check("mret_npc", out_npc, 32'h8000_0010);
    check("mret_redir", {31'b0, out_redirect}, 32'd1);
    take_resp();

    // CSRRS mstatus without write
    w0 = wen_cnt;
    run_op("rs_nowr", 3'd1, 12'h300, 32'h0000_0055, 1'b1, 32'h8000_0020, 2);
    check("rs_nowr_rd", out_rd_data, 32'h0000_1800);
    check("rs_nowr_rdwen", {31'b0, out_rd_wen}, 32'd1);
    check("rs_nowr_wen", wen_cnt, w0);
    check("rs_nowr_mst", m_mstatus, 32'h0000_1800);
    take_resp();

    // CSRRS / CSRRC mstatus with write
    run_op("rs_wr", 3'd1, 12'h300, 32'h0000_0008, 1'b0, 32'h8000_0024, 3);
    check("rs_wr_rd", out_rd_data, 32'h0000_1800);
    check("rs_wr_mst", m_mstatus, 32'h0000_1808);
    check("rs_wr_wen", wen_cnt, w0 + 1);
    take_resp();
    run_op("rc_wr", 3'd2, 12'h300, 32'h0000_1800, 1'b0, 32'h8000_0028, 3);
    check("rc_wr_rd", out_rd_data, 32'h0000_1808);
    check("rc_wr_mst", m_mstatus, 32'h0000_0008);
    check("rc_wr_npc", out_npc, 32'h8000_002C);
    take_resp();

    // Write to read-only marchid traps
    run_op("ro_wr", 3'd0, 12'hF12, 32'h0000_1234, 1'b0, 32'h8000_0200, 4);
    check("ro_wr_mcause", m_mcause, 32'd2);
    check("ro_wr_mepc", m_mepc, 32'h8000_0200);
    check("ro_wr_rdwen", {31'b0, out_rd_wen}, 32'd0);
    check("ro_wr_npc", out_npc, 32'h8000_0100);
    check("ro_wr_redir", {31'b0, out_redirect}, 32'd1);
    take_resp();
    e0 = err_cnt;
    run_op("ro_rd", 3'd1, 12'hF12, 32'h0000_1234, 1'b1, 32'h8000_0204, 2);
    check("ro_rd_rd", out_rd_data, MARCHID);
    check("ro_rd_rdwen", {31'b0, out_rd_wen}, 32'd1);
    check("ro_rd_err", err_cnt, e0);
    take_resp();

    // EBREAK
`ifdef CSRU_EBREAK_EN
    exp_eb = 32'd3;
`else
    exp_eb = 32'd2;
`endif
    run_op("ebreak", 3'd5, 12'h000, 32'h0, 1'b1, 32'h8000_0300, 3);
    check("ebreak_mcause", m_mcause, exp_eb);
    check("ebreak_mepc", m_mepc, 32'h8000_0300);
    take_resp();

    // mtvec low bits masked on trap entry; reserved op is illegal
    run_op("rw_mtvec2", 3'd0, 12'h305, 32'h8000_0103, 1'b0, 32'h8000_0304, 3);
    check("rw_mtvec2_rd", out_rd_data, 32'h8000_0100);
    take_resp();
    run_op("resv", 3'd7, 12'h000, 32'h0, 1'b1, 32'h8000_0400, 3);
    check("resv_mcause", m_mcause, 32'd2);
    check("resv_npc", out_npc, 32'h8000_0100);
    check("resv_rdwen", {31'b0, out_rd_wen}, 32'd0);
    take_resp();

    // Backpressure plus pc wrap
    run_op("bp", 3'd1, 12'h300, 32'h0, 1'b1, 32'hFFFF_FFFC, 2);
    e0 = err_cnt;
    w0 = wen_cnt;
    @(negedge clock);
    in_valid = 1'b1; in_op = 3'd3; in_pc = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_npc", out_npc, 32'h0);
      check("bp_rd", out_rd_data, 32'h0000_0008);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    check("bp_err", err_cnt, e0);
    check("bp_wen", wen_cnt, w0);
    take_resp();
    check("bp_idle_rdy", {31'b0, in_ready}, 32'd1);
    check("bp_idle_valid", {31'b0, out_valid}, 32'd0);

    // Reset during TRAP_CAUSE
    @(negedge clock);
    in_valid = 1'b1; in_op = 3'd3; in_pc = 32'h8000_0500;
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(posedge clock);
    #2;
    check("mid_err_on", {31'b0, csr_err}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_ctl_off", {29'b0, csr_ren, csr_wen, csr_err}, 32'd0);
    check("mid_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_npc", out_npc, 32'h0);
    check("mid_redir", {31'b0, out_redirect}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("mid_mcause", m_mcause, 32'd2);
    check("mid_in_ready2", {31'b0, in_ready}, 32'd1);
    run_op("post_rst", 3'd1, 12'h342, 32'h0, 1'b1, 32'h8000_0600, 2);
    check("post_rst_rd", out_rd_data, 32'd2);
    take_resp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
